// File: rtl/synth_ctrl_pkg.sv
// Shared types and defaults for the synth control path.
//   gate_state_t             : key-gate FSM state encoding
//   DEBOUNCE_CYCLES_DEFAULT  : ~1 ms of stable level at 12.288 MHz
//   RETRIG_GAP_DEFAULT       : gate-low cycles forced on a key change
//   cnt_width()              : counter width for a 0..n-1 count, never 0
package synth_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GATE_ON,
        RETRIG
    } gate_state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 12288;
    localparam int RETRIG_GAP_DEFAULT      = 4;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// One key: 2-flop synchronizer followed by a stable-level debounce counter.
//   clk_i   : system clock
//   rst_ni  : async active-low reset
//   sw_i    : raw switch level, asynchronous to clk_i
//   held_o  : debounced level, flips after DEBOUNCE_CYCLES differing cycles
module key_debouncer
    import synth_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sw_i,
    output logic held_o
);

    localparam int              CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync   <= '0;
            cnt    <= '0;
            held_o <= 1'b0;
        end else begin
            sync <= {sync[0], sw_i};
            // Any cycle where the synced level agrees restarts the count,
            // so only an unbroken run of disagreement is accepted.
            if (sync[1] == held_o) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                held_o <= ~held_o;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_gate_controller.sv
// Key switches -> clean ADSR gate with last-note priority and retrigger gap.
//   clk_i      : 12.288 MHz clock
//   rst_ni     : async active-low reset
//   sw_i       : raw switch levels
//   key_held_o : debounced key levels
//   gate_o     : gate / valid to ADSR and amp modulator
//   retrig_o   : one-cycle pulse on the first cycle of a retrigger gap
//   key_idx_o  : index of the sounding key
module key_gate_controller
    import synth_ctrl_pkg::*;
#(
    parameter int NUM_KEYS        = 5,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int RETRIG_GAP      = RETRIG_GAP_DEFAULT
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_KEYS-1:0]           sw_i,
    output logic [NUM_KEYS-1:0]           key_held_o,
    output logic                          gate_o,
    output logic                          retrig_o,
    output logic [cnt_width(NUM_KEYS)-1:0] key_idx_o
);

    localparam int            IW       = cnt_width(NUM_KEYS);
    localparam int            GW       = cnt_width(RETRIG_GAP);
    // Loaded with GAP-1 so the exit check is "counter is 0" and the gate
    // stays low for exactly RETRIG_GAP cycles.
    localparam logic [GW-1:0] GAP_LOAD = GW'(RETRIG_GAP - 1);

    // ---------------- per-key synchronizer + debounce ----------------
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .sw_i   (sw_i[k]),
            .held_o (key_held_o[k])
        );
    end

    // ---------------- edge events ----------------
    logic [NUM_KEYS-1:0] held_q;
    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] rel;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) held_q <= '0;
        else         held_q <= key_held_o;
    end

    assign press = key_held_o & ~held_q;
    assign rel   = ~key_held_o & held_q;

    function automatic logic [IW-1:0] hi_idx(input logic [NUM_KEYS-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_KEYS; k++)
            if (v[k]) r = IW'(k);
        return r;
    endfunction

    // ---------------- FSM ----------------
    gate_state_t   state, state_n;
    logic [GW-1:0] gap, gap_n;
    logic          gate_n, retrig_n;
    logic [IW-1:0] idx_n;
    logic          any_press, none_held, active_rel;

    assign any_press  = |press;
    assign none_held  = ~|key_held_o;
    assign active_rel = rel[key_idx_o];

    always_comb begin
        state_n  = state;
        gap_n    = gap;
        gate_n   = gate_o;
        retrig_n = 1'b0;
        idx_n    = key_idx_o;
        unique case (state)
            IDLE: begin
                gate_n = 1'b0;
                if (any_press) begin
                    idx_n   = hi_idx(press);
                    gate_n  = 1'b1;
                    state_n = GATE_ON;
                end
            end
            GATE_ON, RETRIG: begin
                // Press outranks release; an empty keyboard outranks a gap.
                if (any_press) begin
                    idx_n    = hi_idx(press);
                    retrig_n = 1'b1;
                    gap_n    = GAP_LOAD;
                    gate_n   = 1'b0;
                    state_n  = RETRIG;
                end else if (none_held) begin
                    gate_n  = 1'b0;
                    state_n = IDLE;
                end else if (active_rel) begin
                    idx_n    = hi_idx(key_held_o);
                    retrig_n = 1'b1;
                    gap_n    = GAP_LOAD;
                    gate_n   = 1'b0;
                    state_n  = RETRIG;
                end else if (state == RETRIG) begin
                    if (gap == '0) begin
                        gate_n  = 1'b1;
                        state_n = GATE_ON;
                    end else begin
                        gap_n = gap - 1'b1;
                    end
                end
            end
            default: begin
                gate_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            gap       <= '0;
            gate_o    <= 1'b0;
            retrig_o  <= 1'b0;
            key_idx_o <= '0;
        end else begin
            state     <= state_n;
            gap       <= gap_n;
            gate_o    <= gate_n;
            retrig_o  <= retrig_n;
            key_idx_o <= idx_n;
        end
    end

endmodule
